// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared widths, RV32I load/store funct3 codes and LSU FSM states.
// Revision : 1.0
// ============================================================================
package load_store_unit_pkg;

    localparam int c_xlen    = 32;
    localparam int c_state_w = 2;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    localparam logic [c_state_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_state_w-1:0] c_st_req  = 2'd1;
    localparam logic [c_state_w-1:0] c_st_done = 2'd2;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Single-outstanding req/ack data-memory port.
// Revision : 1.0
// ============================================================================
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [c_xlen-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [c_xlen-1:0] dmem_wdata;
    logic [c_xlen-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_align
// Purpose  : Byte-enable / store-lane replication, legality check and load
//            lane extraction with sign or zero extension. Purely combinational.
// Revision : 1.0
// ============================================================================
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic              we,
    input  logic [c_xlen-1:0] wdata,
    input  logic [c_xlen-1:0] rdata,
    output logic [3:0]        be,
    output logic [c_xlen-1:0] wdata_rep,
    output logic              fault,
    output logic [c_xlen-1:0] load_data
);

    logic              w_legal;
    logic              w_misalign;
    logic [c_xlen-1:0] w_lane;

    // Unsigned widths exist only for loads.
    always_comb begin
        w_legal = 1'b0;
        case (funct3)
            c_f3_b, c_f3_h, c_f3_w: w_legal = 1'b1;
            c_f3_bu, c_f3_hu:       w_legal = ~we;
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    assign fault      = ~w_legal | w_misalign;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    assign w_lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = '0;
        case (funct3)
            c_f3_b:  load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            c_f3_h:  load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            c_f3_w:  load_data = w_lane;
            c_f3_bu: load_data = {24'd0, w_lane[7:0]};
            c_f3_hu: load_data = {16'd0, w_lane[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-stage LSU: IDLE/REQ/DONE FSM, timeout counter and op
//            capture driving a single-outstanding req/ack data-memory port.
// Revision : 1.0
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   load_data,
    load_store_unit_if.master dmem
);

    localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic [7:0]           r_wait_cnt;
    logic [XLEN-1:0]      r_addr;
    logic [2:0]           r_funct3;
    logic                 r_we;
    logic [3:0]           r_be;
    logic [XLEN-1:0]      r_wdata_rep;
    logic                 r_err;
    logic [XLEN-1:0]      r_load_data;

    logic                 w_in_req;
    logic                 w_open;
    logic                 w_single;
    logic                 w_go;
    logic                 w_reject;
    logic                 w_nxt_err;
    logic [XLEN-1:0]      w_nxt_ldata;

    logic [2:0]           w_al_funct3;
    logic [1:0]           w_al_addr_lo;
    logic                 w_al_we;
    logic [3:0]           w_al_be;
    logic [XLEN-1:0]      w_al_wdata_rep;
    logic                 w_al_fault;
    logic [XLEN-1:0]      w_al_ldata;

    assign w_in_req = (r_state == c_st_req);
    assign w_open   = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_single = mem_read ^ mem_write;
    assign w_go     = w_open & start & w_single & ~w_al_fault;
    assign w_reject = w_open & start & ((w_single & w_al_fault) | (mem_read & mem_write));

    // One aligner serves both phases: live inputs while accepting, captured op while in REQ.
    assign w_al_funct3  = w_in_req ? r_funct3    : funct3;
    assign w_al_addr_lo = w_in_req ? r_addr[1:0] : addr[1:0];
    assign w_al_we      = w_in_req ? r_we        : mem_write;

    load_store_unit_align u_align (
        .funct3    (w_al_funct3),
        .addr_lo   (w_al_addr_lo),
        .we        (w_al_we),
        .wdata     (wdata),
        .rdata     (dmem.dmem_rdata),
        .be        (w_al_be),
        .wdata_rep (w_al_wdata_rep),
        .fault     (w_al_fault),
        .load_data (w_al_ldata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_nxt_err   = 1'b0;
        w_nxt_ldata = '0;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (w_go) begin
                    w_state_nxt = c_st_req;
                end else if (w_reject) begin
                    w_state_nxt = c_st_done;
                    w_nxt_err   = 1'b1;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_req: begin
                if (dmem.dmem_ack) begin
                    w_state_nxt = c_st_done;
                    w_nxt_ldata = r_we ? '0 : w_al_ldata;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_state_nxt = c_st_done;
                    w_nxt_err   = 1'b1;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // err/load_data are only ever non-zero on the edge into DONE, so they self-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_err       <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_err       <= w_nxt_err;
            r_load_data <= w_nxt_ldata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= 8'd0;
            r_addr      <= '0;
            r_funct3    <= 3'b000;
            r_we        <= 1'b0;
            r_be        <= 4'b0000;
            r_wdata_rep <= '0;
        end else if (w_go) begin
            r_wait_cnt  <= 8'd0;
            r_addr      <= addr;
            r_funct3    <= funct3;
            r_we        <= mem_write;
            r_be        <= w_al_be;
            r_wdata_rep <= w_al_wdata_rep;
        end else if (w_in_req && !dmem.dmem_ack) begin
            r_wait_cnt  <= r_wait_cnt + 8'd1;
        end
    end

    assign stall     = w_in_req | w_go;
    assign done      = (r_state == c_st_done);
    assign err       = r_err;
    assign load_data = r_load_data;

    assign dmem.dmem_req   = w_in_req;
    assign dmem.dmem_we    = w_in_req & r_we;
    assign dmem.dmem_addr  = w_in_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign dmem.dmem_be    = w_in_req ? r_be : 4'b0000;
    assign dmem.dmem_wdata = w_in_req ? r_wdata_rep : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed and randomized self-checking bench for load_store_unit.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] load_data;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit_if dmem_if ();

    load_store_unit #(.XLEN(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .dmem      (dmem_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: access size in bytes, alignment by modulo, lanes by byte arithmetic.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd, output logic fault,
                                  output logic [3:0] be, output logic [31:0] wrep,
                                  output logic [31:0] ld);
        int          size;
        int          off;
        bit          legal;
        logic [31:0] v;
        logic [31:0] mask;
        off  = int'(a % 4);
        case (f3[1:0])
            2'b00:   size = 1;
            2'b01:   size = 2;
            2'b10:   size = 4;
            default: size = 0;
        endcase
        if (we) legal = (size != 0) && !f3[2];
        else    legal = (size != 0) && (f3 != 3'b110);
        fault = !legal || ((off % (size == 0 ? 1 : size)) != 0);
        be    = 4'(((1 << size) - 1) << off);
        wrep  = '0;
        for (int i = 0; i < 4; i++)
            wrep[8*i +: 8] = wd[8*(i % (size == 0 ? 4 : size)) +: 8];
        v    = rd >> (8 * off);
        mask = (size >= 4 || size == 0) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        v    = v & mask;
        if (!f3[2] && size > 0 && size < 4 && v[8*size-1]) v = v | ~mask;
        ld = we ? 32'h0 : v;
    endfunction

    // Caller sits 1 time unit after a rising edge; returns likewise, in the DONE
    // cycle when b2b is set, otherwise one cycle later.
    task automatic do_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                         input int ack_delay, input bit b2b);
        logic        fault;
        logic [3:0]  be;
        logic [31:0] wrep;
        logic [31:0] ld;
        bit          go;
        bit          rej;
        bit          tmo;
        model(wr_en, f3, a, wd, rdv, fault, be, wrep, ld);
        go  = (rd_en ^ wr_en) && !fault;
        rej = (rd_en && wr_en) || ((rd_en ^ wr_en) && fault);
        tmo = 1'b0;
        start = 1'b1; mem_read = rd_en; mem_write = wr_en;
        funct3 = f3; addr = a; wdata = wd;
        #1;
        check("stall_accept", 32'(stall), 32'(go));
        @(posedge clk); #1;
        start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (go) begin
            tmo = 1'b1;
            for (int k = 0; k < MAX_WAIT; k++) begin
                check("req_high", 32'(dmem_if.dmem_req), 32'd1);
                check("stall_req", 32'(stall), 32'd1);
                check("dmem_addr", dmem_if.dmem_addr, {a[31:2], 2'b00});
                if (k == 0) begin
                    check("dmem_be", 32'(dmem_if.dmem_be), 32'(be));
                    check("dmem_we", 32'(dmem_if.dmem_we), 32'(wr_en));
                    if (wr_en) check("dmem_wdata", dmem_if.dmem_wdata, wrep);
                end
                if (k == ack_delay) begin
                    dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = rdv;
                end
                @(posedge clk); #1;
                dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = $urandom;
                if (k == ack_delay) begin
                    tmo = 1'b0;
                    break;
                end
            end
        end
        if (go || rej) begin
            check("done", 32'(done), 32'd1);
            check("err", 32'(err), 32'(rej || tmo));
            check("load_data", load_data, (go && !tmo) ? ld : 32'h0);
            check("req_done", 32'(dmem_if.dmem_req), 32'd0);
            check("stall_done", 32'(stall), 32'd0);
        end else begin
            check("ignored_done", 32'(done), 32'd0);
            check("ignored_req", 32'(dmem_if.dmem_req), 32'd0);
        end
        if (!b2b) begin
            @(posedge clk); #1;
            check("idle_done", 32'(done), 32'd0);
            check("idle_err", 32'(err), 32'd0);
            check("idle_ldata", load_data, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = '0; wdata = '0;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ldata", load_data, 32'h0);
        check("rst_req", 32'(dmem_if.dmem_req), 32'd0);
        check("rst_addr", dmem_if.dmem_addr, 32'h0);
        check("rst_be", 32'(dmem_if.dmem_be), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        do_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 1'b0);
        do_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2, 1'b0);
        do_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 1, 1'b0);
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 1'b0);
        do_op(1'b0, 1'b1, 3'b100, 32'h0000_0200, 32'h0, 32'h0, 0, 1'b0);
        do_op(1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 0, 1'b0);
        do_op(1'b0, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 0, 1'b0);
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1111_2222, 100, 1'b1);
        do_op(1'b1, 1'b0, 3'b101, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 14, 1'b1);
        do_op(1'b0, 1'b1, 3'b000, 32'h0000_0501, 32'hCAFE_F00D, 32'h0, 0, 1'b0);

        // Reset during the third REQ cycle, then a stray ack
        start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
        @(posedge clk); #1;
        start = 1'b0; mem_read = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_mid_req_before", 32'(dmem_if.dmem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_req", 32'(dmem_if.dmem_req), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_be", 32'(dmem_if.dmem_be), 32'd0);
        check("rst_mid_addr", dmem_if.dmem_addr, 32'h0);
        rst = 1'b0;
        dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_if.dmem_ack = 1'b0;
        check("stray_ack_done", 32'(done), 32'd0);
        check("stray_ack_ldata", load_data, 32'h0);
        @(posedge clk); #1;
        check("stray_ack_idle", 32'(done), 32'd0);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic        r_en;
            logic        w_en;
            logic [31:0] a;
            int          dly;
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      begin r_en = 1'b1; w_en = 1'b1; end
            else if (kind == 1) begin r_en = 1'b0; w_en = 1'b0; end
            else begin
                r_en = 1'($urandom_range(0, 1));
                w_en = ~r_en;
            end
            a   = $urandom;
            dly = ($urandom_range(0, 7) == 0) ? MAX_WAIT + 3 : int'($urandom_range(0, 3));
            do_op(r_en, w_en, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                  dly, 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
